// File: rtl/gelato_warp_fetch_arbiter.sv
// rtl/gelato_warp_fetch_arbiter.sv - round-robin warp fetch arbiter with per-warp instruction-buffer credits
// Optional perf counters: define GELATO_FETCH_ARB_PERF_EN.
module gelato_warp_fetch_arbiter #(
   parameter int NUM_WARPS  = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int IBUF_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy,
   input  logic [NUM_WARPS-1:0]            warp_active_i,
   input  logic [NUM_WARPS-1:0]            warp_stall_i,
   input  logic [NUM_WARPS*ADDR_WIDTH-1:0] warp_pc_i,
   output logic [NUM_WARPS-1:0]            pc_adv_o,
   input  logic [NUM_WARPS-1:0]            ibuf_pop_i,
`ifdef GELATO_FETCH_ARB_PERF_EN
   output logic [31:0]                     perf_issue_cnt_o,
   output logic [31:0]                     perf_starve_cnt_o,
`endif
   output logic                            req_valid_o,
   input  logic                            req_ready_i,
   output logic [$clog2(NUM_WARPS)-1:0]    req_warp_id_o,
   output logic [ADDR_WIDTH-1:0]           req_pc_o
);
   localparam int IDW = $clog2(NUM_WARPS);
   localparam int CW  = $clog2(IBUF_DEPTH + 1);

   typedef enum logic [0:0] {IDLE, REQ} state_t;

   state_t                state_q, state_d;
   logic                  req_valid_q, req_valid_d;
   logic [IDW-1:0]        id_q, id_d;
   logic [IDW-1:0]        ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [CW-1:0]         credit_q [NUM_WARPS];
   logic [CW-1:0]         credit_d [NUM_WARPS];
   logic [ADDR_WIDTH-1:0] pc_arr   [NUM_WARPS];
   logic [NUM_WARPS-1:0]  elig_now, elig_next;
   logic [IDW:0]          pick_idle, pick_hs;
   logic                  handshake;

   // Lowest offset from base+1 wins; offset NUM_WARPS wraps back to base itself.
   function automatic logic [IDW:0] rr_pick(input logic [NUM_WARPS-1:0] elig,
                                            input logic [IDW-1:0] base);
      logic [IDW:0]   r;
      logic [IDW-1:0] idx;
      r = '0;
      for (int i = NUM_WARPS; i >= 1; i--) begin
         idx = base + IDW'(i);
         if (elig[idx]) r = {1'b1, idx};
      end
      return r;
   endfunction

   assign handshake = req_valid_q && req_ready_i && rdy;

   always_comb begin
      for (int w = 0; w < NUM_WARPS; w++) begin
         pc_arr[w]   = warp_pc_i[w*ADDR_WIDTH +: ADDR_WIDTH];
         credit_d[w] = credit_q[w];
         if (rdy && ibuf_pop_i[w] && !(handshake && id_q == IDW'(w))) begin
            if (credit_q[w] != CW'(IBUF_DEPTH)) credit_d[w] = credit_q[w] + CW'(1);
         end else if (handshake && id_q == IDW'(w) && !(rdy && ibuf_pop_i[w])) begin
            credit_d[w] = credit_q[w] - CW'(1);
         end
         elig_now[w]  = warp_active_i[w] && !warp_stall_i[w] && (credit_q[w] != '0);
         elig_next[w] = warp_active_i[w] && !warp_stall_i[w] && (credit_d[w] != '0);
      end
      pick_idle = rr_pick(elig_now, ptr_q);
      pick_hs   = rr_pick(elig_next, id_q);
   end

   always_comb begin
      state_d = state_q;
      if (rdy) begin
         case (state_q)
            IDLE:    if (pick_idle[IDW]) state_d = REQ;
            REQ:     if (handshake && !pick_hs[IDW]) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      req_valid_d = req_valid_q;
      id_d        = id_q;
      pc_d        = pc_q;
      ptr_d       = ptr_q;
      pc_adv_o    = '0;
      if (rdy && state_q == IDLE && pick_idle[IDW]) begin
         req_valid_d = 1'b1;
         id_d        = pick_idle[IDW-1:0];
         pc_d        = pc_arr[pick_idle[IDW-1:0]];
      end else if (handshake) begin
         pc_adv_o[id_q] = 1'b1;
         ptr_d          = id_q;
         req_valid_d    = pick_hs[IDW];
         if (pick_hs[IDW]) begin
            id_d = pick_hs[IDW-1:0];
            pc_d = pc_arr[pick_hs[IDW-1:0]];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         req_valid_q <= 1'b0;
         id_q        <= '0;
         pc_q        <= '0;
         ptr_q       <= IDW'(NUM_WARPS - 1);
         for (int w = 0; w < NUM_WARPS; w++) credit_q[w] <= CW'(IBUF_DEPTH);
      end else begin
         state_q     <= state_d;
         req_valid_q <= req_valid_d;
         id_q        <= id_d;
         pc_q        <= pc_d;
         ptr_q       <= ptr_d;
         for (int w = 0; w < NUM_WARPS; w++) credit_q[w] <= credit_d[w];
      end
   end

   assign req_valid_o   = req_valid_q;
   assign req_warp_id_o = id_q;
   assign req_pc_o      = pc_q;

`ifdef GELATO_FETCH_ARB_PERF_EN
   logic [31:0] issue_cnt_q, issue_cnt_d;
   logic [31:0] starve_cnt_q, starve_cnt_d;

   // Starved: work exists but credits/stalls block every active warp.
   always_comb begin
      issue_cnt_d  = issue_cnt_q + (handshake ? 32'd1 : 32'd0);
      starve_cnt_d = starve_cnt_q;
      if (rdy && |warp_active_i && !(|elig_now) && !req_valid_q)
         starve_cnt_d = starve_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_cnt_q  <= '0;
         starve_cnt_q <= '0;
      end else begin
         issue_cnt_q  <= issue_cnt_d;
         starve_cnt_q <= starve_cnt_d;
      end
   end

   assign perf_issue_cnt_o  = issue_cnt_q;
   assign perf_starve_cnt_o = starve_cnt_q;
`endif
endmodule

// File: tb/tb_gelato_warp_fetch_arbiter.sv
// tb/tb_gelato_warp_fetch_arbiter.sv - scoreboard bench for gelato_warp_fetch_arbiter
module tb_gelato_warp_fetch_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic [3:0]  active = '0;
   logic [3:0]  stall = '0;
   logic [3:0]  pop = '0;
   logic [3:0]  pc_adv;
   logic        req_valid;
   logic        req_ready = 1'b0;
   logic [1:0]  req_id;
   logic [31:0] req_pc;
   logic [31:0] pcs [4];
   logic [127:0] warp_pc;
`ifdef GELATO_FETCH_ARB_PERF_EN
   logic [31:0] perf_issue, perf_starve;
`endif

   typedef struct {
      logic [1:0]  id;
      logic [31:0] pc;
   } exp_t;
   exp_t sb_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int hs_seen  = 0;

   assign warp_pc = {pcs[3], pcs[2], pcs[1], pcs[0]};

   always #5 clk = ~clk;

   gelato_warp_fetch_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .rdy               (rdy),
      .warp_active_i     (active),
      .warp_stall_i      (stall),
      .warp_pc_i         (warp_pc),
      .pc_adv_o          (pc_adv),
      .ibuf_pop_i        (pop),
`ifdef GELATO_FETCH_ARB_PERF_EN
      .perf_issue_cnt_o  (perf_issue),
      .perf_starve_cnt_o (perf_starve),
`endif
      .req_valid_o       (req_valid),
      .req_ready_i       (req_ready),
      .req_warp_id_o     (req_id),
      .req_pc_o          (req_pc)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted request must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (rdy && req_valid && req_ready) begin
            hs_seen++;
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_req: got warp %0d pc 0x%0h, expected no request", req_id, req_pc);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               check("req_warp_id", 64'(req_id), 64'(e.id));
               check("req_pc", 64'(req_pc), 64'(e.pc));
               check("pc_adv_hs", 64'(pc_adv), 64'(4'b0001 << e.id));
            end
         end else begin
            check("pc_adv_idle", 64'(pc_adv), 64'd0);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [1:0] id, input int n);
      exp_t e;
      e.id = id;
      e.pc = 32'h100 * (32'(id) + 1);
      repeat (n) sb_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_valid_async", 64'(req_valid), 64'd0);
      check("rst_pc_adv", 64'(pc_adv), 64'd0);
      active = '0; stall = '0; pop = '0; req_ready = 1'b0; rdy = 1'b1;
      pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h300; pcs[3] = 32'h400;
      step(2);
      check("rst_warp_id", 64'(req_id), 64'd0);
      check("rst_pc", 64'(req_pc), 64'd0);
      sb_q.delete();
      rst = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int b;
      b = 0;
      step(2);
      while (req_valid && b < 60) begin
         step(1);
         b++;
      end
      step(3);
      check({name, "_valid_low"}, 64'(req_valid), 64'd0);
      check({name, "_sb_empty"}, 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int base;

      // Round robin across four warps until every buffer is full
      do_reset();
      for (int r = 0; r < 4; r++) for (int w = 0; w < 4; w++) push(2'(w), 1);
      active = 4'hF; req_ready = 1'b1;
      wait_idle("rr_all");

      // Stalled warp 1 is skipped
      do_reset();
      for (int r = 0; r < 4; r++) begin push(2'd0, 1); push(2'd2, 1); push(2'd3, 1); end
      active = 4'hF; stall = 4'b0010; req_ready = 1'b1;
      wait_idle("rr_stall");

      // Single warp: exactly IBUF_DEPTH requests, then one per pop
      do_reset();
      push(2'd2, 4);
      active = 4'b0100; req_ready = 1'b1;
      wait_idle("single_w2");
      base = hs_seen;
      push(2'd2, 1);
      pop = 4'b0100;
      step(1);
      pop = '0;
      wait_idle("single_w2_pop");
      check("single_w2_pop_count", 64'(hs_seen - base), 64'd1);

      // Backpressure: id/PC held while warp 1 deactivates and its PC moves
      do_reset();
      active = 4'b0010;
      step(1);
      active = '0; pcs[1] = 32'h999;
      for (int c = 0; c < 5; c++) begin
         check("hold_valid", 64'(req_valid), 64'd1);
         check("hold_id", 64'(req_id), 64'd1);
         check("hold_pc", 64'(req_pc), 64'h200);
         step(1);
      end
      push(2'd1, 1);
      req_ready = 1'b1;
      step(1);
      check("hold_drop_idle", 64'(req_valid), 64'd0);
      pcs[1] = 32'h200;
      push(2'd1, 3);
      active = 4'b0010;
      wait_idle("hold_credit");

      // Pop coinciding with the last-credit handshake keeps warp 0 going
      do_reset();
      push(2'd0, 5);
      active = 4'b0001; req_ready = 1'b1;
      step(4);
      pop = 4'b0001;
      step(1);
      pop = '0;
      wait_idle("pop_same");

      // Saturating pop at full credit, then rdy low freezes a pending request
      do_reset();
      pop = 4'b1000;
      step(2);
      pop = '0;
      active = 4'b1000;
      step(1);
      rdy = 1'b0; req_ready = 1'b1;
      base = hs_seen;
      for (int c = 0; c < 3; c++) begin
         check("rdy_low_valid", 64'(req_valid), 64'd1);
         check("rdy_low_pc_adv", 64'(pc_adv), 64'd0);
         step(1);
      end
      check("rdy_low_no_hs", 64'(hs_seen - base), 64'd0);
      push(2'd3, 4);
      rdy = 1'b1;
      wait_idle("sat_pop");

      // Reset while a request is pending drops it at once
      do_reset();
      active = 4'hF;
      step(1);
      check("mid_req_valid", 64'(req_valid), 64'd1);
      do_reset();
      check("mid_req_after", 64'(req_valid), 64'd0);

`ifdef GELATO_FETCH_ARB_PERF_EN
      do_reset();
      for (int k = 0; k < 10; k++) push(2'(k % 4), 1);
      active = 4'hF; req_ready = 1'b1;
      step(1);
      step(9);
      stall = 4'hF;
      step(4);
      active = '0;
      check("perf_issue", 64'(perf_issue), 64'd10);
      check("perf_starve", 64'(perf_starve), 64'd3);
      check("perf_sb_empty", 64'(sb_q.size()), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/gelato_warp_fetch_arbiter.md
Name: gelato_warp_fetch_arbiter

Overview:
Selects which warp issues the next instruction-fetch PC toward the instruction fetch stage, sharing the single fetch/I-cache path among NUM_WARPS warps. Uses round-robin fairness among eligible warps. Tracks per-warp instruction-buffer credits so a warp never fetches more instructions than its buffer slots. Sits between the split/PC table, the instruction buffer status and the instruction fetch unit.

Parameters:
NUM_WARPS, 4, number of warps arbitrated (power of two, >=2)
ADDR_WIDTH, 32, PC width in bits
IBUF_DEPTH, 4, instruction-buffer slots per warp = initial credits (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
rdy  input  1  global enable; low freezes all state
warp_active_i  input  NUM_WARPS  warp initialised and not finished
warp_stall_i  input  NUM_WARPS  warp blocked (pending branch/split); not eligible
warp_pc_i  input  NUM_WARPS*ADDR_WIDTH  current PC per warp, warp w at [w*ADDR_WIDTH +: ADDR_WIDTH]
pc_adv_o  output  NUM_WARPS  one-hot pulse: PC table advances warp PC by 4
ibuf_pop_i  input  NUM_WARPS  instruction buffer released one slot of warp w
req_valid_o  output  1  fetch request valid
req_ready_i  input  1  fetch unit accepts request
req_warp_id_o  output  $clog2(NUM_WARPS)  warp of request
req_pc_o  output  ADDR_WIDTH  PC of request

Behaviour:
- Reset: req_valid_o=0, req_warp_id_o=0, req_pc_o=0, pc_adv_o=0, all credits=IBUF_DEPTH, rr pointer=NUM_WARPS-1, FSM=IDLE.
- Eligible(w) = warp_active_i[w] && !warp_stall_i[w] && credit[w]!=0.
- FSM IDLE: if rdy and any eligible, pick first eligible scanning from ptr+1 modulo NUM_WARPS. Register warp id and warp_pc_i of winner into req_warp_id_o/req_pc_o, set req_valid_o=1, go REQ. One cycle latency from eligibility to req_valid_o.
- FSM REQ: req_valid_o held 1; id/PC held stable until handshake; no retraction even if the warp goes inactive or stalled.
- Handshake = req_valid_o && req_ready_i && rdy. On handshake: credit[id]-=1; pc_adv_o[id]=1 combinationally in that cycle only; ptr<=id. If another warp (or same) is eligible using the post-decrement credit, load next request and stay in REQ (back-to-back, one request per cycle). Otherwise req_valid_o<=0 and go IDLE.
- ibuf_pop_i[w] with rdy: credit[w]+=1. Simultaneous pop and issue on the same warp: credit unchanged. Pop when credit==IBUF_DEPTH is ignored (saturate).
- Credit width $clog2(IBUF_DEPTH+1); no wrap below 0 (issue only when credit!=0 guarantees this).
- rdy low: no state change, outputs hold, pc_adv_o=0, handshake not counted even if req_ready_i=1.
- Reset asserted mid-request: request dropped immediately (req_valid_o=0 asynchronously), credits restored.
- Single eligible warp: issues every cycle until credit exhausted.

Optional Feature:
GELATO_FETCH_ARB_PERF_EN: adds outputs perf_issue_cnt_o (32) counting handshakes and perf_starve_cnt_o (32) counting rdy cycles where some warp is active but none eligible and req_valid_o=0. Both reset to 0 and wrap modulo 2^32. Without the macro the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, all 4 warps active, PCs 0x100/0x200/0x300/0x400, req_ready_i=1 -> requests warp 0,1,2,3,0,... one per cycle with PCs from warp_pc_i; pc_adv_o one-hot per handshake.
- Only warp 2 active, no pops, IBUF_DEPTH=4 -> exactly 4 requests for warp 2, then req_valid_o=0. Single ibuf_pop_i[2] -> exactly one more request.
- req_ready_i=0 for 5 cycles while warp 1 requesting and warp 1 deactivated meanwhile -> id=1 and PC held stable for 5 cycles; handshake on cycle 6; credit[1] decremented.
- ibuf_pop_i[0] in the same cycle as warp 0 handshake with credit 1 -> credit stays 1 and warp 0 is re-requested next.
- rdy=0 with req_ready_i=1 -> no pc_adv_o, no credit change. Pop at full credit -> credit stays 4.
- With GELATO_FETCH_ARB_PERF_EN, 10 handshakes then 3 cycles where all active warps are stalled -> perf_issue_cnt_o=10, perf_starve_cnt_o=3.
